// File: rtl/branch_resolve_unit.sv
// Branch resolution in EXE: compares the IF prediction with the actual outcome, trains the predictor, drives the mispredict redirect.
// Latency: BResult and redirect are registered, 1 cycle after the resolve event (or 1 cycle after DS_InID rises if the delay slot is late).
// Backpressure: Redirect_Valid is held until Redirect_Ack; EXE_Wr=0 stalls resolution. Optional counters: define BRU_STATS_EN.
//
// EXE_PResult layout [36:0]: {Valid, Hit, IsTaken, Target[31:0], Count[1:0]}
// EXE_BResult layout [70:0]: {Valid, PC[31:0], Target[31:0], Type[1:0], IsTaken, Hit, Count[1:0]}

`ifndef BIsNone
`define BIsNone 2'd0
`endif
`ifndef BIsImme
`define BIsImme 2'd1
`endif
`ifndef BIsCall
`define BIsCall 2'd2
`endif
`ifndef BIsRetn
`define BIsRetn 2'd3
`endif

module branch_resolve_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_Valid,
  input  logic        EXE_Wr,
  input  logic        EXE_Flush,
  input  logic [31:0] EXE_PC,
  input  logic [1:0]  EXE_BType,
  input  logic        EXE_Cond,
  input  logic [31:0] EXE_ImmTarget,
  input  logic [31:0] EXE_RegTarget,
  input  logic [36:0] EXE_PResult,
  input  logic        DS_InID,
  input  logic        Redirect_Ack,
  output logic [70:0] EXE_BResult,
  output logic        Redirect_Valid,
  output logic [31:0] Redirect_PC,
  output logic        IF_Flush,
  output logic [31:0] Stat_Branches,
  output logic [31:0] Stat_Mispredicts
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_DS = 2'd1,
    S_REDIR   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] latched_pc;

  // Prediction fields unpacked from the IF record
  logic        p_valid;
  logic        p_hit;
  logic        p_taken;
  logic [31:0] p_target;
  logic [1:0]  p_count;

  assign p_valid  = EXE_PResult[36];
  assign p_hit    = EXE_PResult[35];
  assign p_taken  = EXE_PResult[34];
  assign p_target = EXE_PResult[33:2];
  assign p_count  = EXE_PResult[1:0];

  logic        act_taken;
  logic [31:0] act_target;
  logic        pred_taken;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic        resolve;

  // Calls and returns are unconditional; only immediate branches look at the condition
  assign act_taken  = (EXE_BType == `BIsImme) ? EXE_Cond : 1'b1;
  assign act_target = (EXE_BType == `BIsRetn) ? EXE_RegTarget : EXE_ImmTarget;
  // An invalid prediction means IF fetched sequentially, i.e. effectively not-taken
  assign pred_taken = p_valid & p_taken;
  assign mispredict = (pred_taken != act_taken) |
                      (pred_taken & act_taken & (p_target != act_target));
  // Fall-through skips the delay slot
  assign correct_pc = act_taken ? act_target : (EXE_PC + 32'd8);
  // Only resolve in IDLE: anything in EXE during WAIT_DS/REDIR is wrong-path or the delay slot
  assign resolve    = EXE_Valid & EXE_Wr & (EXE_BType != `BIsNone) &
                      (state == S_IDLE) & ~EXE_Flush;

  // Training record: Valid pulses once per resolve, payload holds between events
  always_ff @(posedge clk) begin
    if (rst) begin
      EXE_BResult <= '0;
    end else begin
      EXE_BResult[70] <= resolve;
      if (resolve) begin
        EXE_BResult[69:0] <= {EXE_PC, act_target, EXE_BType, act_taken, p_hit, p_count};
      end
    end
  end

  // Redirect FSM with registered Redirect_Valid / Redirect_PC / IF_Flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      latched_pc     <= RESET_PC;
      Redirect_Valid <= 1'b0;
      Redirect_PC    <= RESET_PC;
      IF_Flush       <= 1'b0;
    end else if (EXE_Flush) begin
      // Exception/ERET redirect owns PREIF; abandon any pending correction
      state          <= S_IDLE;
      latched_pc     <= RESET_PC;
      Redirect_Valid <= 1'b0;
      Redirect_PC    <= RESET_PC;
      IF_Flush       <= 1'b0;
    end else begin
      IF_Flush <= 1'b0;
      case (state)
        S_IDLE: begin
          if (resolve && mispredict) begin
            latched_pc <= correct_pc;
            if (DS_InID) begin
              state          <= S_REDIR;
              Redirect_Valid <= 1'b1;
              Redirect_PC    <= correct_pc;
              IF_Flush       <= 1'b1;
            end else begin
              state <= S_WAIT_DS;
            end
          end
        end
        S_WAIT_DS: begin
          if (DS_InID) begin
            state          <= S_REDIR;
            Redirect_Valid <= 1'b1;
            Redirect_PC    <= latched_pc;
            IF_Flush       <= 1'b1;
          end
        end
        S_REDIR: begin
          if (Redirect_Ack) begin
            state          <= S_IDLE;
            Redirect_Valid <= 1'b0;
            Redirect_PC    <= RESET_PC;
          end
        end
        default: begin
          state          <= S_IDLE;
          Redirect_Valid <= 1'b0;
          Redirect_PC    <= RESET_PC;
        end
      endcase
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] stat_br;
  logic [31:0] stat_mis;

  // Saturating event counters, only counting right-path resolves
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br  <= '0;
      stat_mis <= '0;
    end else begin
      if (resolve && (stat_br != 32'hFFFF_FFFF)) begin
        stat_br <= stat_br + 32'd1;
      end
      if (resolve && mispredict && (stat_mis != 32'hFFFF_FFFF)) begin
        stat_mis <= stat_mis + 32'd1;
      end
    end
  end

  assign Stat_Branches    = stat_br;
  assign Stat_Mispredicts = stat_mis;
`else
  assign Stat_Branches    = '0;
  assign Stat_Mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table plus hand-written multi-cycle sequences.
// Inputs change on the falling edge, outputs are sampled on the falling edge after each rising edge.
module tb_branch_resolve_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [1:0]  B_NONE = 2'd0;
  localparam logic [1:0]  B_IMME = 2'd1;
  localparam logic [1:0]  B_CALL = 2'd2;
  localparam logic [1:0]  B_RETN = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXE_Valid, EXE_Wr, EXE_Flush;
  logic [31:0] EXE_PC;
  logic [1:0]  EXE_BType;
  logic        EXE_Cond;
  logic [31:0] EXE_ImmTarget, EXE_RegTarget;
  logic [36:0] EXE_PResult;
  logic        DS_InID, Redirect_Ack;
  logic [70:0] EXE_BResult;
  logic        Redirect_Valid;
  logic [31:0] Redirect_PC;
  logic        IF_Flush;
  logic [31:0] Stat_Branches, Stat_Mispredicts;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .EXE_Valid(EXE_Valid), .EXE_Wr(EXE_Wr), .EXE_Flush(EXE_Flush),
    .EXE_PC(EXE_PC), .EXE_BType(EXE_BType), .EXE_Cond(EXE_Cond),
    .EXE_ImmTarget(EXE_ImmTarget), .EXE_RegTarget(EXE_RegTarget),
    .EXE_PResult(EXE_PResult), .DS_InID(DS_InID), .Redirect_Ack(Redirect_Ack),
    .EXE_BResult(EXE_BResult), .Redirect_Valid(Redirect_Valid),
    .Redirect_PC(Redirect_PC), .IF_Flush(IF_Flush),
    .Stat_Branches(Stat_Branches), .Stat_Mispredicts(Stat_Mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  btype;
    logic        cond;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rtgt;
    logic        pv;
    logic        ph;
    logic        pt;
    logic [31:0] ptgt;
    logic [1:0]  pcnt;
    logic        exp_taken;
    logic [31:0] exp_tgt;
    logic        exp_mis;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [1:0] btype, input logic cond, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rtgt,
                         input logic pv, input logic ph, input logic pt,
                         input logic [31:0] ptgt, input logic [1:0] pcnt,
                         input logic exp_taken, input logic [31:0] exp_tgt,
                         input logic exp_mis, input logic [31:0] exp_rpc);
    vec_t v;
    v.btype = btype; v.cond = cond; v.pc = pc; v.imm = imm; v.rtgt = rtgt;
    v.pv = pv; v.ph = ph; v.pt = pt; v.ptgt = ptgt; v.pcnt = pcnt;
    v.exp_taken = exp_taken; v.exp_tgt = exp_tgt; v.exp_mis = exp_mis; v.exp_rpc = exp_rpc;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    EXE_Valid = 1'b0; EXE_Wr = 1'b0; EXE_Flush = 1'b0;
    EXE_PC = '0; EXE_BType = B_NONE; EXE_Cond = 1'b0;
    EXE_ImmTarget = '0; EXE_RegTarget = '0; EXE_PResult = '0;
    DS_InID = 1'b0; Redirect_Ack = 1'b0;
  endtask

  task automatic drive_branch(input logic [1:0] btype, input logic cond, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [31:0] rtgt,
                              input logic pv, input logic ph, input logic pt,
                              input logic [31:0] ptgt, input logic [1:0] pcnt, input logic ds);
    EXE_Valid = 1'b1; EXE_Wr = 1'b1; EXE_BType = btype; EXE_Cond = cond;
    EXE_PC = pc; EXE_ImmTarget = imm; EXE_RegTarget = rtgt;
    EXE_PResult = {pv, ph, pt, ptgt, pcnt};
    DS_InID = ds;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    idle_inputs();
    rst = 1'b1;

    // btype  cond pc            imm           rtgt          pv ph pt ptgt          cnt  taken tgt           mis  rpc
    add_vec(B_IMME, 1, 32'h8000_0100, 32'h8000_0200, 32'h0,        1, 1, 1, 32'h8000_0200, 3,   1, 32'h8000_0200, 0, RST_PC);
    add_vec(B_IMME, 0, 32'h8000_0100, 32'h8000_0200, 32'h0,        1, 1, 1, 32'h8000_0200, 2,   0, 32'h8000_0200, 1, 32'h8000_0108);
    add_vec(B_RETN, 1, 32'h8000_2000, 32'h1234_5678, 32'h8000_3000, 0, 0, 0, 32'h0,        0,   1, 32'h8000_3000, 1, 32'h8000_3000);
    add_vec(B_IMME, 0, 32'h8000_0400, 32'h8000_0000, 32'h0,        1, 1, 0, 32'h0,        1,   0, 32'h8000_0000, 0, RST_PC);
    add_vec(B_CALL, 0, 32'h8000_0600, 32'h8000_4000, 32'h0,        1, 0, 1, 32'h8000_4004, 2,   1, 32'h8000_4000, 1, 32'h8000_4000);
    add_vec(B_IMME, 1, 32'h8000_0700, 32'h8000_0080, 32'h0,        1, 1, 0, 32'h0,        0,   1, 32'h8000_0080, 1, 32'h8000_0080);
    add_vec(B_IMME, 0, 32'hFFFF_FFFC, 32'h0000_0010, 32'h0,        0, 0, 0, 32'h0,        0,   0, 32'h0000_0010, 0, RST_PC);
    add_vec(B_IMME, 0, 32'hFFFF_FFFC, 32'h0000_0010, 32'h0,        1, 1, 1, 32'h0000_0010, 3,   0, 32'h0000_0010, 1, 32'h0000_0004);
    add_vec(B_RETN, 1, 32'h8000_0800, 32'h0,        32'h8000_5000, 1, 1, 1, 32'h8000_5000, 3,   1, 32'h8000_5000, 0, RST_PC);
    add_vec(B_IMME, 1, 32'h8000_0900, 32'h8000_0300, 32'h0,        0, 1, 1, 32'h8000_0300, 1,   1, 32'h8000_0300, 1, 32'h8000_0300);

    // Reset state
    step(); step();
    chk("reset_bresult", EXE_BResult, 71'd0);
    chk("reset_rv", 71'(Redirect_Valid), 71'd0);
    chk("reset_rpc", 71'(Redirect_PC), 71'(RST_PC));
    chk("reset_flush", 71'(IF_Flush), 71'd0);
    chk("reset_stat_br", 71'(Stat_Branches), 71'd0);
    chk("reset_stat_mis", 71'(Stat_Mispredicts), 71'd0);
    rst = 1'b0;

    // Table-driven single-branch resolves (delay slot already in ID)
    foreach (vq[i]) begin
      drive_branch(vq[i].btype, vq[i].cond, vq[i].pc, vq[i].imm, vq[i].rtgt,
                   vq[i].pv, vq[i].ph, vq[i].pt, vq[i].ptgt, vq[i].pcnt, 1'b1);
      step();
      idle_inputs();
      chk($sformatf("vec%0d_bresult", i), EXE_BResult,
          {1'b1, vq[i].pc, vq[i].exp_tgt, vq[i].btype, vq[i].exp_taken, vq[i].ph, vq[i].pcnt});
      chk($sformatf("vec%0d_rv", i), 71'(Redirect_Valid), 71'(vq[i].exp_mis));
      chk($sformatf("vec%0d_rpc", i), 71'(Redirect_PC), 71'(vq[i].exp_rpc));
      chk($sformatf("vec%0d_flush", i), 71'(IF_Flush), 71'(vq[i].exp_mis));
      Redirect_Ack = vq[i].exp_mis;
      step();
      Redirect_Ack = 1'b0;
      chk($sformatf("vec%0d_bres_drop", i), 71'(EXE_BResult[70]), 71'd0);
      chk($sformatf("vec%0d_rv_after", i), 71'(Redirect_Valid), 71'd0);
    end

    // Mispredict, redirect held, flush pulses once, ack on second REDIR cycle
    drive_branch(B_IMME, 0, 32'h8000_0100, 32'h8000_0200, 0, 1, 1, 1, 32'h8000_0200, 2, 1'b1);
    step(); idle_inputs();
    chk("hold_rv1", 71'(Redirect_Valid), 71'd1);
    chk("hold_rpc1", 71'(Redirect_PC), 71'h8000_0108);
    chk("hold_flush1", 71'(IF_Flush), 71'd1);
    step();
    chk("hold_rv2", 71'(Redirect_Valid), 71'd1);
    chk("hold_rpc2", 71'(Redirect_PC), 71'h8000_0108);
    chk("hold_flush2", 71'(IF_Flush), 71'd0);
    Redirect_Ack = 1'b1;
    step(); Redirect_Ack = 1'b0;
    chk("hold_rv_acked", 71'(Redirect_Valid), 71'd0);
    chk("hold_rpc_acked", 71'(Redirect_PC), 71'(RST_PC));

    // Late delay slot: wait three cycles, wrong-path branch ignored, then redirect
    drive_branch(B_IMME, 1, 32'h8000_0400, 32'h8000_0500, 0, 1, 0, 0, 0, 0, 1'b0);
    step(); idle_inputs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("waitds_rv%0d", k), 71'(Redirect_Valid), 71'd0);
      if (k < 2) step();
    end
    drive_branch(B_IMME, 1, 32'h8000_0404, 32'h8000_0600, 0, 1, 0, 0, 0, 0, 1'b0);
    step(); idle_inputs();
    chk("waitds_suppress_bres", 71'(EXE_BResult[70]), 71'd0);
    chk("waitds_suppress_rv", 71'(Redirect_Valid), 71'd0);
    DS_InID = 1'b1;
    step(); DS_InID = 1'b0;
    chk("waitds_rv", 71'(Redirect_Valid), 71'd1);
    chk("waitds_rpc", 71'(Redirect_PC), 71'h8000_0500);
    chk("waitds_flush", 71'(IF_Flush), 71'd1);
    Redirect_Ack = 1'b1;
    step(); Redirect_Ack = 1'b0;
    chk("waitds_rv_acked", 71'(Redirect_Valid), 71'd0);

    // EXE_Flush during REDIR drops the redirect; unit is back in IDLE
    drive_branch(B_IMME, 0, 32'h8000_0100, 32'h8000_0200, 0, 1, 1, 1, 32'h8000_0200, 2, 1'b1);
    step(); idle_inputs();
    chk("flush_redir_rv_before", 71'(Redirect_Valid), 71'd1);
    EXE_Flush = 1'b1;
    step(); EXE_Flush = 1'b0;
    chk("flush_redir_rv", 71'(Redirect_Valid), 71'd0);
    chk("flush_redir_flush", 71'(IF_Flush), 71'd0);
    chk("flush_redir_rpc", 71'(Redirect_PC), 71'(RST_PC));
    drive_branch(B_IMME, 1, 32'h8000_0A00, 32'h8000_0B00, 0, 1, 1, 1, 32'h8000_0B00, 3, 1'b1);
    step(); idle_inputs();
    chk("flush_redir_idle_bres", 71'(EXE_BResult[70]), 71'd1);

    // Flush coincident with a branch in IDLE: no training, no redirect
    drive_branch(B_IMME, 0, 32'h8000_0100, 32'h8000_0200, 0, 1, 1, 1, 32'h8000_0200, 2, 1'b1);
    EXE_Flush = 1'b1;
    step(); idle_inputs();
    chk("flush_idle_bres", 71'(EXE_BResult[70]), 71'd0);
    chk("flush_idle_rv", 71'(Redirect_Valid), 71'd0);

    // Stalled branch: four EXE_Wr=0 cycles then one advance -> exactly one BResult
    pulses = 0;
    drive_branch(B_IMME, 1, 32'h8000_0C00, 32'h8000_0D00, 0, 1, 1, 1, 32'h8000_0D00, 3, 1'b1);
    EXE_Wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (EXE_BResult[70]) pulses++;
    end
    EXE_Wr = 1'b1;
    step(); idle_inputs();
    if (EXE_BResult[70]) pulses++;
    for (int k = 0; k < 3; k++) begin
      step();
      if (EXE_BResult[70]) pulses++;
    end
    chk("stall_pulses", 71'(pulses), 71'd1);

    // Back-to-back correctly predicted branches: one record per cycle
    for (int k = 0; k < 3; k++) begin
      drive_branch(B_IMME, 0, 32'h8000_1000 + 32'(4 * k), 32'h8000_2000, 0, 1, 1, 0, 0, 1, 1'b1);
      step();
      chk($sformatf("b2b%0d_bres", k), EXE_BResult,
          {1'b1, 32'h8000_1000 + 32'(4 * k), 32'h8000_2000, B_IMME, 1'b0, 1'b1, 2'd1});
    end
    idle_inputs();
    step();

    // Reset asserted mid-redirect returns to full reset state
    drive_branch(B_IMME, 0, 32'h8000_0100, 32'h8000_0200, 0, 1, 1, 1, 32'h8000_0200, 2, 1'b1);
    step(); idle_inputs();
    chk("rst_mid_rv_before", 71'(Redirect_Valid), 71'd1);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("rst_mid_rv", 71'(Redirect_Valid), 71'd0);
    chk("rst_mid_flush", 71'(IF_Flush), 71'd0);
    chk("rst_mid_rpc", 71'(Redirect_PC), 71'(RST_PC));
    chk("rst_mid_bres", EXE_BResult, 71'd0);
    step();
    chk("rst_mid_no_residual", 71'({Redirect_Valid, IF_Flush}), 71'd0);

    // Statistics: 5 branches, 2 mispredicts
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1 || k == 3) begin
        drive_branch(B_IMME, 0, 32'h8000_0100, 32'h8000_0200, 0, 1, 1, 1, 32'h8000_0200, 2, 1'b1);
        step(); idle_inputs();
        Redirect_Ack = 1'b1;
        step(); Redirect_Ack = 1'b0;
      end else begin
        drive_branch(B_IMME, 1, 32'h8000_0100, 32'h8000_0200, 0, 1, 1, 1, 32'h8000_0200, 3, 1'b1);
        step(); idle_inputs();
      end
    end
    step();
`ifdef BRU_STATS_EN
    chk("stat_branches", 71'(Stat_Branches), 71'd5);
    chk("stat_mispredicts", 71'(Stat_Mispredicts), 71'd2);
`else
    chk("stat_branches", 71'(Stat_Branches), 71'd0);
    chk("stat_mispredicts", 71'(Stat_Mispredicts), 71'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
